mcpu5_run_controller: RTL and testbench

Host-side run controller for the MCPU5 core. Holds a small instruction memory loaded over a valid/ready stream, then drives the core's `inst_in`, `clk` and `rst` pins as a 3-cycle-per-instruction sequence. It demultiplexes the core's time-shared `cpu_out` bus into captured PC and accumulator values, and turns OUT instructions into a back-pressured output stream. It also supports halting on stop or breakpoint.

---
 rtl/mcpu5_run_controller_if.sv | 28 ++
 rtl/mcpu5_run_controller.sv | 216 +++++++++++++++++++++
 tb/tb_mcpu5_run_controller.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mcpu5_run_controller_if.sv
// Stream bundle for the MCPU5 run controller: program-load input stream
// and OUT-instruction output stream, both valid/ready.
interface mcpu5_run_controller_if;
    logic       load_valid;
    logic [5:0] load_data;
    logic       load_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;

    modport master (
        output load_valid,
        output load_data,
        input  load_ready,
        input  out_valid,
        input  out_data,
        output out_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready,
        output out_valid,
        output out_data,
        input  out_ready
    );
endinterface

// File: rtl/mcpu5_run_controller.sv
// Host-side run controller for the MCPU5 core. Loads a small program
// memory, then steps the core through reset and a 3-cycle-per-instruction
// clock sequence. It splits the time-shared cpu_data bus into PC and
// accumulator captures and turns OUT instructions into a back-pressured
// stream.
module mcpu5_run_controller #(
    parameter int         AW  = 5,
    parameter logic [5:0] NOP = 6'b111011
) (
    input  logic                  clk,
    input  logic                  rst,
    mcpu5_run_controller_if.slave bus,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  bkpt_en,
    input  logic [AW-1:0]         bkpt_addr,
    output logic                  cpu_clk,
    output logic                  cpu_rst,
    output logic [5:0]            cpu_inst,
    input  logic [7:0]            cpu_data,
    output logic                  running,
    output logic                  halted,
    output logic [7:0]            pc_q,
    output logic [7:0]            acc_q,
    output logic [15:0]           steps
);
    localparam logic [5:0] OP_OUT = 6'b111001;

    typedef enum logic [2:0] {
        S_IDLE, S_CR_LO, S_CR_HI, S_FETCH, S_EXEC_LO, S_EXEC_HI
    } state_t;

    state_t          state_r, state_nxt_s;
    logic [AW-1:0]   wptr_r;
    logic [5:0]      mem_r [0:(2**AW)-1];
    logic            cpu_clk_r, cpu_rst_r, running_r, halted_r, load_ready_r, out_valid_r;
    logic [5:0]      cpu_inst_r;
    logic [7:0]      pc_q_r, acc_q_r, out_data_r;
    logic [15:0]     steps_r;

    logic            cpu_clk_nxt_s, cpu_rst_nxt_s, halted_nxt_s, out_valid_nxt_s;
    logic [5:0]      cpu_inst_nxt_s;
    logic [7:0]      pc_nxt_s, acc_nxt_s, out_data_nxt_s;
    logic [15:0]     steps_nxt_s, steps_inc_s;
    logic            capture_s, clear_out_s, restart_s, load_fire_s, bkpt_hit_s, stall_s;

    assign load_fire_s = bus.load_valid && load_ready_r;
    assign bkpt_hit_s  = bkpt_en && (pc_q_r[AW-1:0] == bkpt_addr);
    // An OUT must wait while the previous value is still unclaimed.
    assign stall_s     = (cpu_inst_r == OP_OUT) && out_valid_r && !bus.out_ready;
    assign steps_inc_s = (steps_r == 16'hFFFF) ? steps_r : (steps_r + 16'd1);

    // Sequencer: next state plus the per-state captures and status updates.
    always_comb begin
        state_nxt_s    = state_r;
        cpu_inst_nxt_s = cpu_inst_r;
        halted_nxt_s   = halted_r;
        steps_nxt_s    = steps_r;
        pc_nxt_s       = pc_q_r;
        acc_nxt_s      = acc_q_r;
        capture_s      = 1'b0;
        clear_out_s    = 1'b0;
        restart_s      = 1'b0;
        case (state_r)
            S_IDLE: begin
                // Parked on NOP; after a stall-halt the OUT is held one more
                // cycle so the instruction only changes with cpu_clk high.
                cpu_inst_nxt_s = NOP;
                if (start) begin
                    state_nxt_s  = S_CR_LO;
                    halted_nxt_s = 1'b0;
                    steps_nxt_s  = 16'd0;
                    clear_out_s  = 1'b1;
                    restart_s    = 1'b1;
                end else begin
                    state_nxt_s  = S_IDLE;
                end
            end
            S_CR_LO: begin
                state_nxt_s = S_CR_HI;
            end
            S_CR_HI: begin
                state_nxt_s = S_FETCH;
                pc_nxt_s    = 8'd0;
            end
            S_FETCH: begin
                if (stop || bkpt_hit_s) begin
                    state_nxt_s    = S_IDLE;
                    halted_nxt_s   = 1'b1;
                    cpu_inst_nxt_s = NOP;
                end else begin
                    state_nxt_s    = S_EXEC_LO;
                    cpu_inst_nxt_s = mem_r[pc_q_r[AW-1:0]];
                end
            end
            S_EXEC_LO: begin
                if (stall_s) begin
                    if (stop) begin
                        state_nxt_s  = S_IDLE;
                        halted_nxt_s = 1'b1;
                        acc_nxt_s    = cpu_data;
                        steps_nxt_s  = steps_inc_s;
                    end else begin
                        state_nxt_s  = S_EXEC_LO;
                    end
                end else begin
                    state_nxt_s = S_EXEC_HI;
                    capture_s   = (cpu_inst_r == OP_OUT);
                    acc_nxt_s   = cpu_data;
                    steps_nxt_s = steps_inc_s;
                end
            end
            S_EXEC_HI: begin
                state_nxt_s = S_FETCH;
                pc_nxt_s    = cpu_data;
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // Core clock/reset pins are a pure function of the state being entered.
    always_comb begin
        cpu_clk_nxt_s = 1'b1;
        cpu_rst_nxt_s = 1'b0;
        case (state_nxt_s)
            S_IDLE:    begin cpu_clk_nxt_s = 1'b1; cpu_rst_nxt_s = 1'b0; end
            S_CR_LO:   begin cpu_clk_nxt_s = 1'b0; cpu_rst_nxt_s = 1'b1; end
            S_CR_HI:   begin cpu_clk_nxt_s = 1'b1; cpu_rst_nxt_s = 1'b1; end
            S_FETCH:   begin cpu_clk_nxt_s = 1'b1; cpu_rst_nxt_s = 1'b0; end
            S_EXEC_LO: begin cpu_clk_nxt_s = 1'b0; cpu_rst_nxt_s = 1'b0; end
            S_EXEC_HI: begin cpu_clk_nxt_s = 1'b1; cpu_rst_nxt_s = 1'b0; end
            default:   begin cpu_clk_nxt_s = 1'b1; cpu_rst_nxt_s = 1'b0; end
        endcase
    end

    // Output stream: a new capture wins over a simultaneous accept.
    always_comb begin
        out_valid_nxt_s = out_valid_r;
        out_data_nxt_s  = out_data_r;
        if (clear_out_s) begin
            out_valid_nxt_s = 1'b0;
        end else if (capture_s) begin
            out_valid_nxt_s = 1'b1;
            out_data_nxt_s  = cpu_data;
        end else if (bus.out_ready) begin
            out_valid_nxt_s = 1'b0;
        end else begin
            out_valid_nxt_s = out_valid_r;
        end
    end

    // State and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= S_IDLE;
            cpu_clk_r    <= 1'b1;
            cpu_rst_r    <= 1'b0;
            cpu_inst_r   <= NOP;
            running_r    <= 1'b0;
            halted_r     <= 1'b0;
            load_ready_r <= 1'b1;
            out_valid_r  <= 1'b0;
            out_data_r   <= 8'd0;
            pc_q_r       <= 8'd0;
            acc_q_r      <= 8'd0;
            steps_r      <= 16'd0;
        end else begin
            state_r      <= state_nxt_s;
            cpu_clk_r    <= cpu_clk_nxt_s;
            cpu_rst_r    <= cpu_rst_nxt_s;
            cpu_inst_r   <= cpu_inst_nxt_s;
            running_r    <= (state_nxt_s != S_IDLE);
            halted_r     <= halted_nxt_s;
            load_ready_r <= (state_nxt_s == S_IDLE);
            out_valid_r  <= out_valid_nxt_s;
            out_data_r   <= out_data_nxt_s;
            pc_q_r       <= pc_nxt_s;
            acc_q_r      <= acc_nxt_s;
            steps_r      <= steps_nxt_s;
        end
    end

    // Load write pointer; start rewinds it even if a word lands that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_r <= {AW{1'b0}};
        end else if (restart_s) begin
            wptr_r <= {AW{1'b0}};
        end else if (load_fire_s) begin
            wptr_r <= wptr_r + AW'(1);
        end else begin
            wptr_r <= wptr_r;
        end
    end

    // Program memory write port; contents are not reset.
    always_ff @(posedge clk) begin
        if (load_fire_s) begin
            mem_r[wptr_r] <= bus.load_data;
        end
    end

    assign cpu_clk        = cpu_clk_r;
    assign cpu_rst        = cpu_rst_r;
    assign cpu_inst       = cpu_inst_r;
    assign running        = running_r;
    assign halted         = halted_r;
    assign pc_q           = pc_q_r;
    assign acc_q          = acc_q_r;
    assign steps          = steps_r;
    assign bus.load_ready = load_ready_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.out_data   = out_data_r;
endmodule

// File: tb/tb_mcpu5_run_controller.sv
// Bench for mcpu5_run_controller: a tiny MCPU5 core model drives cpu_data,
// and an instruction-level reference model predicts PC, accumulator, step
// count and the OUT stream.
module tb_mcpu5_run_controller;
    localparam int         AW     = 5;
    localparam logic [5:0] NOP    = 6'b111011;
    localparam logic [5:0] OP_OUT = 6'b111001;

    logic clk = 1'b0;
    logic rst, start, stop, bkpt_en;
    logic [AW-1:0] bkpt_addr;
    logic cpu_clk, cpu_rst, running, halted;
    logic [5:0] cpu_inst;
    logic [7:0] cpu_data, pc_q, acc_q;
    logic [15:0] steps;

    mcpu5_run_controller_if bus();

    mcpu5_run_controller #(.AW(AW), .NOP(NOP)) dut (
        .clk(clk), .rst(rst), .bus(bus), .start(start), .stop(stop),
        .bkpt_en(bkpt_en), .bkpt_addr(bkpt_addr), .cpu_clk(cpu_clk),
        .cpu_rst(cpu_rst), .cpu_inst(cpu_inst), .cpu_data(cpu_data),
        .running(running), .halted(halted), .pc_q(pc_q), .acc_q(acc_q),
        .steps(steps)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic rand_ready = 1'b0;
    logic [7:0] got_q [$];
    logic [7:0] exp_q [$];
    logic [5:0] prog [32];
    logic [7:0] pc_e, acc_e;

    // Instruction subset: 00iiii BCC rel (carry never set), 01iiii LDI sext, rest advance PC.
    function automatic logic [15:0] isa(input logic [5:0] ins, input logic [7:0] pc, input logic [7:0] acc);
        logic [7:0] imm;
        imm = {{4{ins[3]}}, ins[3:0]};
        if (ins[5:4] == 2'b00) return {pc + imm, acc};
        else if (ins[5:4] == 2'b01) return {pc + 8'd1, imm};
        else return {pc + 8'd1, acc};
    endfunction

    // Core model: executes on rising cpu_clk, shows PC while high, accu while low.
    logic [7:0] core_pc = 8'd0, core_acc = 8'd0;
    always @(posedge cpu_clk) begin
        if (cpu_rst === 1'b1) {core_pc, core_acc} <= 16'd0;
        else {core_pc, core_acc} <= isa(cpu_inst, core_pc, core_acc);
    end
    assign cpu_data = cpu_clk ? core_pc : core_acc;

    // Output stream monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1)
            got_q.push_back(bus.out_data);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic load_word(input logic [5:0] w);
        bus.load_valid = 1'b1;
        bus.load_data  = w;
        tick();
        bus.load_valid = 1'b0;
    endtask

    task automatic load_prog(input int n);
        for (int i = 0; i < n; i++) load_word(prog[i]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_until_idle(input int budget, input string tag);
        int n;
        n = 0;
        while (running === 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_idle"}, running, 32'd0);
    endtask

    // Reference: run n instructions from reset; returns PC after them and the
    // accumulator the core showed while executing the last one.
    task automatic ref_run(input int n, output logic [7:0] pc_o, output logic [7:0] acc_o);
        logic [7:0] pc, acc, accp;
        logic [15:0] r;
        logic [5:0] ins;
        pc = 8'd0; acc = 8'd0; accp = 8'd0;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            ins  = prog[pc[AW-1:0]];
            accp = acc;
            if (ins == OP_OUT) exp_q.push_back(acc);
            r   = isa(ins, pc, acc);
            pc  = r[15:8];
            acc = r[7:0];
        end
        pc_o  = pc;
        acc_o = accp;
    endtask

    task automatic cmp_stream(input string tag);
        chk({tag, "_nout"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk({tag, "_out"}, {24'd0, got_q[i]}, {24'd0, exp_q[i]});
    endtask

    function automatic logic [5:0] rand_inst();
        int r;
        r = $urandom_range(0, 3);
        if (r < 2) return {2'b01, 4'($urandom_range(0, 15))};
        else if (r == 2) return OP_OUT;
        else return NOP;
    endfunction

    initial begin
        int first, nvalid, len, t, k, n;
        rst = 1'b1; start = 1'b0; stop = 1'b0; bkpt_en = 1'b0; bkpt_addr = '0;
        bus.load_valid = 1'b0; bus.load_data = 6'd0; bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // Reset state
        chk("rst_running", running, 0);   chk("rst_halted", halted, 0);
        chk("rst_ready", bus.load_ready, 1); chk("rst_cpuclk", cpu_clk, 1);
        chk("rst_cpurst", cpu_rst, 0);    chk("rst_inst", cpu_inst, NOP);
        chk("rst_ovalid", bus.out_valid, 0); chk("rst_steps", steps, 0);
        chk("rst_pc", pc_q, 0);           chk("rst_acc", acc_q, 0);

        // Basic OUT run with start-up timing
        prog[0] = 6'b010101; prog[1] = OP_OUT; prog[2] = 6'b000000;
        load_prog(3);
        got_q.delete();
        pulse_start();
        chk("crlo_rst", cpu_rst, 1); chk("crlo_clk", cpu_clk, 0);
        chk("crlo_ready", bus.load_ready, 0); chk("crlo_run", running, 1);
        first = -1; nvalid = 0;
        for (int j = 1; j <= 30; j++) begin
            tick();
            if (j == 1) begin chk("crhi_clk", cpu_clk, 1); chk("crhi_rst", cpu_rst, 1); end
            if (j == 2) begin chk("fetch_rst", cpu_rst, 0); chk("fetch_clk", cpu_clk, 1); end
            if (j == 3) begin chk("exlo_clk", cpu_clk, 0); chk("exlo_inst", cpu_inst, 6'b010101); end
            if (j == 7) chk("acc_at_exhi", acc_q, 8'h05);
            if (bus.out_valid === 1'b1) begin
                if (first < 0) first = j;
                nvalid++;
            end
        end
        chk("ovalid_rise", first, 7); chk("ovalid_count", nvalid, 1);
        chk("loop_pc", pc_q, 2);
        ref_run(10, pc_e, acc_e);
        cmp_stream("basic");
        stop = 1'b1; run_until_idle(10, "basic"); stop = 1'b0;
        chk("basic_halted", halted, 1);

        // OUT back-pressure stall, then release with capture+accept overlap
        prog[0] = 6'b010101; prog[1] = OP_OUT; prog[2] = 6'b010011; prog[3] = OP_OUT; prog[4] = 6'b000000;
        load_prog(5);
        got_q.delete();
        bus.out_ready = 1'b0;
        pulse_start();
        repeat (20) tick();
        chk("stall_run", running, 1); chk("stall_clk", cpu_clk, 0);
        chk("stall_steps", steps, 3); chk("stall_ovalid", bus.out_valid, 1);
        chk("stall_odata", bus.out_data, 8'h05);
        bus.out_ready = 1'b1;
        repeat (6) tick();
        chk("stall_pc", pc_q, 4);
        stop = 1'b1; run_until_idle(10, "stall"); stop = 1'b0;
        ref_run(8, pc_e, acc_e);
        cmp_stream("stall");

        // Stop during an OUT stall drops the new value
        load_prog(5);
        got_q.delete();
        bus.out_ready = 1'b0;
        pulse_start();
        repeat (15) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("sstop_run", running, 0); chk("sstop_halted", halted, 1);
        chk("sstop_clk", cpu_clk, 1); chk("sstop_ovalid", bus.out_valid, 1);
        chk("sstop_odata", bus.out_data, 8'h05);
        tick();
        chk("sstop_nop", cpu_inst, NOP);
        bus.out_ready = 1'b1;
        repeat (2) tick();
        exp_q.delete(); exp_q.push_back(8'h05);
        cmp_stream("sstop");

        // Breakpoint
        prog[0] = 6'b010101; prog[1] = OP_OUT; prog[2] = 6'b000000;
        load_prog(3);
        got_q.delete();
        bkpt_en = 1'b1; bkpt_addr = 5'd2;
        pulse_start();
        run_until_idle(40, "bkpt");
        chk("bkpt_halted", halted, 1); chk("bkpt_pc", pc_q, 2);
        chk("bkpt_steps", steps, 2); chk("bkpt_clk", cpu_clk, 1);
        chk("bkpt_inst", cpu_inst, NOP);
        bkpt_en = 1'b0;

        // Random program, stop at a random cycle
        for (int it = 0; it < 4; it++) begin
            len = $urandom_range(3, 8);
            for (int i = 0; i < len - 1; i++) prog[i] = rand_inst();
            prog[len-1] = 6'b000000;
            load_prog(len);
            got_q.delete();
            pulse_start();
            t = $urandom_range(5, 25);
            repeat (t) tick();
            stop = 1'b1;
            n = 0;
            while (running === 1'b1 && n < 12) begin tick(); n++; end
            stop = 1'b0;
            k = (t - 2 + 2) / 3;
            chk("rstop_lat", n, 3 * k + 3 - t);
            chk("rstop_halted", halted, 1);
            chk("rstop_steps", steps, k);
            ref_run(k, pc_e, acc_e);
            chk("rstop_pc", pc_q, pc_e);
            chk("rstop_acc", acc_q, acc_e);
            cmp_stream("rstop");
            pulse_start();
            chk("restart_halted", halted, 0); chk("restart_steps", steps, 0);
            stop = 1'b1; run_until_idle(10, "restart"); stop = 1'b0;
        end

        // Random programs with random back-pressure, halted by breakpoint
        for (int it = 0; it < 6; it++) begin
            len = $urandom_range(3, 12);
            for (int i = 0; i < len - 1; i++) prog[i] = rand_inst();
            prog[len-1] = 6'b000000;
            load_prog(len);
            got_q.delete();
            bkpt_en = 1'b1; bkpt_addr = AW'(len - 1);
            rand_ready = 1'b1;
            pulse_start();
            run_until_idle(600, "rbp");
            rand_ready = 1'b0;
            bus.out_ready = 1'b1;
            repeat (2) tick();
            ref_run(len - 1, pc_e, acc_e);
            chk("rbp_steps", steps, len - 1);
            chk("rbp_pc", pc_q, pc_e);
            chk("rbp_acc", acc_q, acc_e);
            cmp_stream("rbp");
        end
        bkpt_en = 1'b0;

        // 34 words wrap onto addresses 0 and 1
        for (int i = 0; i < 32; i++) load_word(6'($urandom_range(0, 63)));
        load_word(6'b011010);
        load_word(6'b000000);
        pulse_start();
        repeat (15) tick();
        chk("wrap_acc", acc_q, 8'hFA); chk("wrap_pc", pc_q, 1);
        stop = 1'b1; run_until_idle(10, "wrap"); stop = 1'b0;

        // Asynchronous reset mid EXEC_LO
        load_word(6'b010111);
        load_word(6'b000000);
        pulse_start();
        repeat (3) tick();
        chk("arst_pre_clk", cpu_clk, 0);
        rst = 1'b1;
        #1;
        chk("arst_run", running, 0); chk("arst_ready", bus.load_ready, 1);
        chk("arst_clk", cpu_clk, 1); chk("arst_cpurst", cpu_rst, 0);
        chk("arst_inst", cpu_inst, NOP); chk("arst_steps", steps, 0);
        chk("arst_pc", pc_q, 0); chk("arst_acc", acc_q, 0);
        #2 rst = 1'b0;
        load_word(6'b010011);
        load_word(6'b000000);
        rst = 1'b1;
        #2 rst = 1'b0;
        load_word(6'b011100);
        load_word(6'b000000);
        pulse_start();
        repeat (12) tick();
        chk("arst_wptr_acc", acc_q, 8'hFC); chk("arst_wptr_pc", pc_q, 1);
        stop = 1'b1; run_until_idle(10, "final"); stop = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
